ram_mult_sequencer: RTL and testbench
=====================================

Name: ram_mult_sequencer

Overview:
- Batch controller that sequences the shared `ram` and `multiplier` blocks.
- For each of N elements it reads operand A and operand B from RAM, starts one multiplication, and writes the 2*DATA_W product back to RAM as two DATA_W words, low word first.
- Sits between the top-level host and the `ram`/`multiplier` instances.
- It is the only master of the RAM bus while busy.

Parameters:
- ADDR_W, 4: RAM address width. All address arithmetic is mod 2^ADDR_W.
- DATA_W, 4: RAM word width and multiplier operand width. The product is 2*DATA_W wide.
- TIMEOUT_CYCLES, 64: multiplier watchdog limit. Used only when SEQ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (clears when reset==0).
- go  in  1  start request; sampled only in IDLE.
- base_a  in  ADDR_W  address of the first A operand.
- base_b  in  ADDR_W  address of the first B operand.
- base_r  in  ADDR_W  address of the first result word.
- count  in  ADDR_W  number of elements to process (0..2^ADDR_W-1).
- busy  out  1  high from the cycle after go is accepted until done.
- done  out  1  one-cycle pulse at the end of a batch.
- err  out  1  sticky timeout flag; cleared by the next accepted go.
- ram_address  out  ADDR_W  RAM address.
- ram_data  inout  DATA_W  RAM data bus; driven only while ram_write==1, otherwise Z.
- ram_write  out  1  RAM write enable.
- mult_start  out  1  multiplier start pulse.
- mult_a  out  DATA_W  multiplier operand A.
- mult_b  out  DATA_W  multiplier operand B.
- mult_res  in  2*DATA_W  multiplier product.
- mult_ready  in  1  multiplier result valid.

Behaviour:
- Reset values: busy=0, done=0, err=0, ram_write=0, ram_data=Z, ram_address=0, mult_start=0, mult_a=0, mult_b=0, element index=0, state=IDLE.
- Reset mid-operation aborts the batch immediately. No further RAM writes occur; partial results already written remain in RAM.
- States: IDLE, RD_A, LAT_A, RD_B, LAT_B, MSTART, MARM, MWAIT, WR_LO, WR_HI, NEXT, FIN.
- IDLE
  - go==1 and count!=0: latch the bases and count, clear err and the index, go to RD_A.
  - go==1 and count==0: go to FIN. No RAM or multiplier activity.
  - go is ignored in every state other than IDLE.
- RD_A: ram_address = base_a + i, ram_write=0.
- LAT_A: hold the address; capture ram_data into mult_a.
- RD_B / LAT_B: same as RD_A / LAT_A using base_b + i, capturing into mult_b.
- MSTART: mult_start=1 for exactly one cycle. mult_a and mult_b stay stable from here until the next LAT_A.
- MARM: one cycle in which mult_ready is ignored (guards against a stale ready level).
- MWAIT: stay until mult_ready==1, then capture mult_res into the product register P.
- WR_LO: ram_address = base_r + 2i, drive ram_data = P[DATA_W-1:0], ram_write=1 for one cycle.
- WR_HI: ram_address = base_r + 2i + 1, drive ram_data = P[2*DATA_W-1:DATA_W], ram_write=1 for one cycle.
- NEXT: ram_write=0 and the bus is released. i = i + 1. If i == count go to FIN, else go to RD_A.
- FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Address wrap:
  - All additions truncate to ADDR_W bits.
  - Result writes may overwrite operands or wrap past 2^ADDR_W-1 to 0. This is allowed and not detected.
- Per-element latency: 9 cycles plus the number of cycles spent in MWAIT.
- Batch latency from go to done: count*(9 + MWAIT cycles) + 2.
- Bus contention rule:
  - ram_data is never driven in the same cycle as a read state.
  - ram_write and the ram_data drive are asserted and removed together.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in MWAIT.
  - If mult_ready is not seen within TIMEOUT_CYCLES cycles, set err=1, skip WR_LO/WR_HI for that element, and go to FIN (the batch is aborted).
  - done still pulses.
- Not defined: MWAIT waits indefinitely, err is tied to 0, and no counter logic is present.

Test Plan:
- Single element:
  - Setup: ram[0]=3, ram[8]=5, base_a=0, base_b=8, base_r=12, count=1, go pulse.
  - Required: ram[12]=F, ram[13]=0, done pulses once, busy low afterwards.
- Batch of 4:
  - Setup: ram[0..3]={1,2,F,0}, ram[4..7]={F,7,F,9}, base_r=8.
  - Required: ram[8..15]={F,0,E,0,1,E,0,0}. Check exactly 4 mult_start pulses.
- count=0 with go:
  - Required: done pulses within 2 cycles.
  - Required: ram_write and mult_start never assert, and the bus stays Z.
- Wrap:
  - Setup: ram[1]=6, ram[2]=7, base_a=1, base_b=2, base_r=F, count=1.
  - Required: ram[F]=A, ram[0]=2 (6*7=0x2A).
- Reset and ignored go:
  - go asserted again mid-batch: ignored; the result set is unchanged.
  - reset driven to 0 during MWAIT: immediately busy=0, ram_write=0, ram_data=Z, mult_start=0. After release, a fresh batch completes correctly.
- Timeout (SEQ_TIMEOUT_EN defined, mult_ready held 0):
  - Required: err=1 and done pulse TIMEOUT_CYCLES+~2 cycles after MSTART.
  - Required: no RAM write for that element.

Source files
------------

// File: rtl/ram_mult_sequencer.sv
// Batch sequencer: for each element, reads A and B from the shared RAM, runs one multiply and writes the product back low word first.
// Optional multiplier watchdog is compiled in with `define SEQ_TIMEOUT_EN.
module ram_mult_sequencer #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [ADDR_W-1:0]     base_a,
    input  logic [ADDR_W-1:0]     base_b,
    input  logic [ADDR_W-1:0]     base_r,
    input  logic [ADDR_W-1:0]     count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     ram_address,
    inout  wire  [DATA_W-1:0]     ram_data,
    output logic                  ram_write,
    output logic                  mult_start,
    output logic [DATA_W-1:0]     mult_a,
    output logic [DATA_W-1:0]     mult_b,
    input  logic [2*DATA_W-1:0]   mult_res,
    input  logic                  mult_ready
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RD_A   = 4'd1;
    localparam logic [3:0] S_LAT_A  = 4'd2;
    localparam logic [3:0] S_RD_B   = 4'd3;
    localparam logic [3:0] S_LAT_B  = 4'd4;
    localparam logic [3:0] S_MSTART = 4'd5;
    localparam logic [3:0] S_MARM   = 4'd6;
    localparam logic [3:0] S_MWAIT  = 4'd7;
    localparam logic [3:0] S_WR_LO  = 4'd8;
    localparam logic [3:0] S_WR_HI  = 4'd9;
    localparam logic [3:0] S_NEXT   = 4'd10;
    localparam logic [3:0] S_FIN    = 4'd11;

    logic [3:0]            state;
    logic [3:0]            state_nxt;
    logic [ADDR_W-1:0]     idx;
    logic [ADDR_W-1:0]     idx_inc;
    logic [ADDR_W-1:0]     base_a_r;
    logic [ADDR_W-1:0]     base_b_r;
    logic [ADDR_W-1:0]     base_r_r;
    logic [ADDR_W-1:0]     count_r;
    logic [ADDR_W-1:0]     wr_off;
    logic [2*DATA_W-1:0]   prod;
    logic [DATA_W-1:0]     wr_word;
    logic                  tmo_hit;

    assign idx_inc = idx + 1'b1;
    assign wr_off  = idx << 1;

    // Watchdog: counts MWAIT cycles and aborts the batch when the multiplier never answers
`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == S_MWAIT) && !mult_ready &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == S_IDLE && go) begin
                err <= 1'b0;
            end else if (tmo_hit) begin
                err <= 1'b1;
            end
            if (state == S_MARM) begin
                tmo_cnt <= '0;
            end else if (state == S_MWAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = (count != '0) ? S_RD_A : S_FIN;
                end
            end
            S_RD_A:   state_nxt = S_LAT_A;
            S_LAT_A:  state_nxt = S_RD_B;
            S_RD_B:   state_nxt = S_LAT_B;
            S_LAT_B:  state_nxt = S_MSTART;
            S_MSTART: state_nxt = S_MARM;
            S_MARM:   state_nxt = S_MWAIT;
            S_MWAIT: begin
                if (mult_ready) begin
                    state_nxt = S_WR_LO;
                end else if (tmo_hit) begin
                    state_nxt = S_FIN;
                end
            end
            S_WR_LO:  state_nxt = S_WR_HI;
            S_WR_HI:  state_nxt = S_NEXT;
            S_NEXT:   state_nxt = (idx_inc == count_r) ? S_FIN : S_RD_A;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, product register and element index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            base_a_r <= '0;
            base_b_r <= '0;
            base_r_r <= '0;
            count_r  <= '0;
            mult_a   <= '0;
            mult_b   <= '0;
            prod     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        base_a_r <= base_a;
                        base_b_r <= base_b;
                        base_r_r <= base_r;
                        count_r  <= count;
                        idx      <= '0;
                    end
                end
                S_LAT_A: mult_a <= ram_data;
                S_LAT_B: mult_b <= ram_data;
                S_MWAIT: begin
                    if (mult_ready) begin
                        prod <= mult_res;
                    end
                end
                S_NEXT:  idx <= idx_inc;
                default: ;
            endcase
        end
    end

    // Bus drive is decoded from state so an async reset releases it at once
    always_comb begin
        ram_address = '0;
        case (state)
            S_RD_A, S_LAT_A: ram_address = base_a_r + idx;
            S_RD_B, S_LAT_B: ram_address = base_b_r + idx;
            S_WR_LO:         ram_address = base_r_r + wr_off;
            S_WR_HI:         ram_address = base_r_r + wr_off + 1'b1;
            default:         ram_address = '0;
        endcase
    end

    assign wr_word    = (state == S_WR_HI) ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
    assign ram_write  = (state == S_WR_LO) || (state == S_WR_HI);
    assign ram_data   = ram_write ? wr_word : {DATA_W{1'bz}};
    assign mult_start = (state == S_MSTART);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FIN);

endmodule

// File: tb/tb_ram_mult_sequencer.sv
// Directed bench for ram_mult_sequencer with a behavioural RAM and a delay-programmable multiplier.
module tb_ram_mult_sequencer;
    localparam int ADDR_W         = 4;
    localparam int DATA_W         = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                go;
    logic [ADDR_W-1:0]   base_a, base_b, base_r, count;
    logic                busy, done, err;
    logic [ADDR_W-1:0]   ram_address;
    wire  [DATA_W-1:0]   ram_data;
    logic                ram_write, mult_start;
    logic [DATA_W-1:0]   mult_a, mult_b;
    logic [2*DATA_W-1:0] mult_res;
    logic                mult_ready = 1'b0;

    always #5 clk = ~clk;

    ram_mult_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .go(go),
        .base_a(base_a), .base_b(base_b), .base_r(base_r), .count(count),
        .busy(busy), .done(done), .err(err),
        .ram_address(ram_address), .ram_data(ram_data), .ram_write(ram_write),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_res(mult_res), .mult_ready(mult_ready)
    );

    // RAM: combinational read, written by the DUT or by the bench preload port
    logic [DATA_W-1:0] mem [16];
    logic              ld_en;
    logic [3:0]        ld_addr;
    logic [3:0]        ld_data;

    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_data;
        else if (ld_en) mem[ld_addr] <= ld_data;
    end
    assign ram_data = ram_write ? {DATA_W{1'bz}} : mem[ram_address];

    // Multiplier: ready rises mdelay cycles after start and stays high until the next start
    int   mdelay;
    logic mhold;
    int   mcnt = 0;
    always @(posedge clk) begin
        if (mult_start) begin
            mult_res   <= {4'b0, mult_a} * {4'b0, mult_b};
            mcnt       <= mdelay;
            mult_ready <= 1'b0;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !mhold) mult_ready <= 1'b1;
        end
    end

    int n_start = 0, n_write = 0, n_done = 0;
    always @(posedge clk) begin
        if (mult_start) n_start <= n_start + 1;
        if (ram_write)  n_write <= n_write + 1;
        if (done)       n_done  <= n_done + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int s_start, s_write, s_done;
    int lat;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic snap();
        s_start = n_start; s_write = n_write; s_done = n_done;
    endtask

    task automatic run(input logic [3:0] ba, input logic [3:0] bb, input logic [3:0] br,
                       input logic [3:0] cnt, output int l);
        @(negedge clk);
        base_a = ba; base_b = bb; base_r = br; count = cnt; go = 1'b1;
        l = 0;
        do begin
            @(negedge clk);
            go = 1'b0;
            l++;
        end while (!done && l < 400);
        if (!done) check_eq("done_wait_expired", 32'(done), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) check_eq("done_wait_expired", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b0; go = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        base_a = '0; base_b = '0; base_r = '0; count = '0;
        mdelay = 2; mhold = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_ram_write", 32'(ram_write), 0);
        check_eq("rst_mult_start", 32'(mult_start), 0);
        check_eq("rst_mult_ab", {24'd0, mult_a, mult_b}, 0);
        check_eq("rst_ram_address", 32'(ram_address), 0);
        reset = 1'b1;

        // Single element: 3*5 = 0x0F
        poke(4'd0, 4'd3); poke(4'd8, 4'd5);
        mdelay = 2; snap();
        run(4'd0, 4'd8, 4'd12, 4'd1, lat);
        check_eq("t1_latency", 32'(lat), 32'd12);
        @(negedge clk);
        check_eq("t1_busy_after", 32'(busy), 0);
        check_eq("t1_ram12", 32'(mem[12]), 32'hF);
        check_eq("t1_ram13", 32'(mem[13]), 32'h0);
        check_eq("t1_done_pulses", 32'(n_done - s_done), 1);
        check_eq("t1_writes", 32'(n_write - s_write), 2);

        // Batch of four
        poke(4'd0, 4'h1); poke(4'd1, 4'h2); poke(4'd2, 4'hF); poke(4'd3, 4'h0);
        poke(4'd4, 4'hF); poke(4'd5, 4'h7); poke(4'd6, 4'hF); poke(4'd7, 4'h9);
        mdelay = 3; snap();
        run(4'd0, 4'd4, 4'd8, 4'd4, lat);
        check_eq("t2_latency", 32'(lat), 32'd49);
        @(negedge clk);
        begin
            logic [3:0] exp2 [8];
            exp2 = '{4'hF, 4'h0, 4'hE, 4'h0, 4'h1, 4'hE, 4'h0, 4'h0};
            for (int i = 0; i < 8; i++)
                check_eq($sformatf("t2_ram%0d", 8 + i), 32'(mem[8 + i]), 32'(exp2[i]));
        end
        check_eq("t2_starts", 32'(n_start - s_start), 4);
        check_eq("t2_busy_after", 32'(busy), 0);

        // count == 0
        snap();
        run(4'd5, 4'd6, 4'd7, 4'd0, lat);
        check_eq("t3_latency", 32'(lat), 32'd1);
        @(negedge clk);
        check_eq("t3_writes", 32'(n_write - s_write), 0);
        check_eq("t3_starts", 32'(n_start - s_start), 0);
        check_eq("t3_done_pulses", 32'(n_done - s_done), 1);

        // Result address wraps past 0xF: 6*7 = 0x2A
        poke(4'd1, 4'd6); poke(4'd2, 4'd7);
        mdelay = 1;
        run(4'd1, 4'd2, 4'hF, 4'd1, lat);
        check_eq("t4_latency", 32'(lat), 32'd11);
        @(negedge clk);
        check_eq("t4_ramF", 32'(mem[15]), 32'hA);
        check_eq("t4_ram0", 32'(mem[0]), 32'h2);

        // go re-asserted mid-batch with other parameters must be ignored
        poke(4'd0, 4'd3); poke(4'd1, 4'd4); poke(4'd4, 4'd5); poke(4'd5, 4'd6);
        mdelay = 2; snap();
        @(negedge clk);
        base_a = 4'd0; base_b = 4'd4; base_r = 4'd8; count = 4'd2; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        base_r = 4'd12; count = 4'd3; go = 1'b1;
        repeat (3) @(negedge clk);
        go = 1'b0;
        wait_done(100);
        @(negedge clk);
        check_eq("t5_ram8", 32'(mem[8]), 32'hF);
        check_eq("t5_ram9", 32'(mem[9]), 32'h0);
        check_eq("t5_ramA", 32'(mem[10]), 32'h8);
        check_eq("t5_ramB", 32'(mem[11]), 32'h1);
        check_eq("t5_ramC_untouched", 32'(mem[12]), 32'h1);
        check_eq("t5_starts", 32'(n_start - s_start), 2);
        check_eq("t5_writes", 32'(n_write - s_write), 4);
        check_eq("t5_done_pulses", 32'(n_done - s_done), 1);

        // Reset during MWAIT aborts, then a fresh batch completes
        poke(4'd0, 4'd5); poke(4'd1, 4'd3);
        mdelay = 30; snap();
        @(negedge clk);
        base_a = 4'd0; base_b = 4'd1; base_r = 4'd6; count = 4'd1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        begin
            int k;
            k = 0;
            while (!mult_start && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!mult_start) check_eq("t6_start_wait_expired", 32'(mult_start), 1);
        end
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_busy_in_mwait", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_busy", 32'(busy), 0);
        check_eq("t6_rst_ram_write", 32'(ram_write), 0);
        check_eq("t6_rst_mult_start", 32'(mult_start), 0);
        check_eq("t6_rst_ram_address", 32'(ram_address), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6_no_writes", 32'(n_write - s_write), 0);
        check_eq("t6_no_done", 32'(n_done - s_done), 0);
        mdelay = 2;
        run(4'd0, 4'd1, 4'd6, 4'd1, lat);
        check_eq("t6_fresh_latency", 32'(lat), 32'd12);
        @(negedge clk);
        check_eq("t6_ram6", 32'(mem[6]), 32'hF);
        check_eq("t6_ram7", 32'(mem[7]), 32'h0);
        check_eq("t6_err", 32'(err), 0);

`ifdef SEQ_TIMEOUT_EN
        // Multiplier never answers: watchdog aborts the batch
        mhold = 1'b1; snap();
        @(negedge clk);
        base_a = 4'd0; base_b = 4'd1; base_r = 4'd2; count = 4'd1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        begin
            int k;
            k = 0;
            while (!mult_start && k < 20) begin
                @(negedge clk);
                k++;
            end
            k = 0;
            while (!done && k < 200) begin
                @(negedge clk);
                k++;
            end
            check_eq("t7_timeout_latency", 32'(k), 32'(TIMEOUT_CYCLES + 2));
        end
        @(negedge clk);
        check_eq("t7_err", 32'(err), 1);
        check_eq("t7_no_writes", 32'(n_write - s_write), 0);
        mhold = 1'b0;
        run(4'd0, 4'd0, 4'd0, 4'd0, lat);
        @(negedge clk);
        check_eq("t7_err_cleared", 32'(err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end
endmodule
